// File: rtl/data_mem_param.sv
// data_mem_param
// Data memory for the RV32I MEM stage. Word-organised RAM with byte/half/word
// loads and stores, sign or zero extension on loads, and one memory-mapped LED
// register. Stores and loads that straddle a word boundary are split into two
// RAM cycles by a small FSM, and the core is held through clk_stall meanwhile.
//
// Ports
//   clk          core clock, all state on posedge
//   rst          asynchronous, active-high reset
//   addr         byte address of the access
//   write_data   store data, right-aligned (byte in [7:0], half in [15:0])
//   memwrite     store request
//   memread      load request (wins if both are raised)
//   sign_mask    [2:0] size 001/011/111, [3] sign-extend loads
//   read_data    extended load result, valid while read_valid is high
//   read_valid   one-cycle pulse marking a completed load
//   led          LED register
//   clk_stall    core must hold every request input stable
//   access_fault one-cycle pulse for a rejected access
//
// INIT_FILE names the RAM image used by the FPGA memory-initialisation step;
// the RTL itself leaves the RAM contents undefined at power-up.
module data_mem_param #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter int          LED_WIDTH   = 8,
  parameter string       INIT_FILE   = "verilog/data.hex"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic                 read_valid,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 access_fault
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, SPLIT1, SPLIT2} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] lo_buf;
  logic        split_load;

  logic [2:0]       nbytes;
  logic [3:0]       lane_base;
  logic             size_ok;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] rd_idx;
  logic             in_range;
  logic             led_hit;
  logic             crossing;
  logic             req;
  logic             bad;
  logic             store;
  logic             accepting;
  logic [7:0]       lanes8;
  logic [63:0]      wdata64;
  logic [31:0]      rd_word;
  logic [31:0]      load_word;
  logic [31:0]      split_word;
  logic [31:0]      led_ext;
  logic [3:0]       wr_lanes;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_word;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] size,
                                         input logic sgn);
    case (size)
      3'b001:  return {{24{sgn & w[7]}}, w[7:0]};
      3'b011:  return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Request decode. BASE_ADDR is a multiple of the RAM size, so the word index
  // is simply the low address bits above the byte offset. An access spanning
  // past the last word fails the range test, so idx+1 of an accepted crossing
  // access is always inside the RAM.
  always_comb begin
    size_ok   = 1'b1;
    nbytes    = 3'd4;
    lane_base = 4'b1111;
    case (sign_mask[2:0])
      3'b001:  begin nbytes = 3'd1; lane_base = 4'b0001; end
      3'b011:  begin nbytes = 3'd2; lane_base = 4'b0011; end
      3'b111:  begin nbytes = 3'd4; lane_base = 4'b1111; end
      default: size_ok = 1'b0;
    endcase
    off       = addr[1:0];
    idx       = addr[IDX_W+1:2];
    idx_next  = idx + IDX_W'(1);
    in_range  = (addr >= BASE_ADDR) && (({1'b0, addr} + {30'b0, nbytes}) <= RAM_END);
    led_hit   = (addr == LED_ADDR);
    crossing  = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    req       = memread | memwrite;
    store     = memwrite & ~memread;
    bad       = !size_ok || (!led_hit && !in_range);
    accepting = (state != SPLIT1);
    // Byte lanes and data over a two-word window: [3:0]/[31:0] land in word
    // idx, [7:4]/[63:32] spill into word idx+1.
    lanes8    = {4'b0000, lane_base} << off;
    wdata64   = {32'b0, write_data} << {off, 3'b000};
  end

  // The stall has to reach the core in the same cycle the crossing request
  // appears, so it is decoded combinationally rather than registered.
  always_comb begin
    clk_stall = !rst && ((accepting && req && !bad && !led_hit && crossing) ||
                         (state == SPLIT1));
  end

  // Read side: the second word of a split comes from idx+1. For a split the
  // low word was captured into lo_buf, and the merged window is realigned.
  always_comb begin
    rd_idx    = (state == SPLIT1) ? idx_next : idx;
    rd_word   = mem[rd_idx];
    load_word = rd_word >> {off, 3'b000};
    case (off)
      2'd0:    split_word = lo_buf;
      2'd1:    split_word = {rd_word[7:0],  lo_buf[31:8]};
      2'd2:    split_word = {rd_word[15:0], lo_buf[31:16]};
      default: split_word = {rd_word[23:0], lo_buf[31:24]};
    endcase
    led_ext = '0;
    led_ext[LED_WIDTH-1:0] = led;
  end

  // Write port. Reset blocks every write so a split store interrupted in
  // SPLIT1 never commits its upper half.
  always_comb begin
    wr_lanes = 4'b0000;
    wr_idx   = idx;
    wr_word  = wdata64[31:0];
    if (!rst) begin
      if (state == SPLIT1) begin
        if (!split_load) begin
          wr_lanes = lanes8[7:4];
          wr_idx   = idx_next;
          wr_word  = wdata64[63:32];
        end
      end else if (store && !bad && !led_hit) begin
        wr_lanes = lanes8[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_lanes[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
    end
  end

  // Control FSM and registered outputs. SPLIT2 accepts a new request just like
  // IDLE, since the core is no longer stalled there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      read_data    <= '0;
      read_valid   <= 1'b0;
      led          <= '0;
      access_fault <= 1'b0;
      lo_buf       <= '0;
      split_load   <= 1'b0;
    end else begin
      read_valid   <= 1'b0;
      access_fault <= 1'b0;
      case (state)
        SPLIT1: begin
          if (split_load) begin
            read_data  <= extend(split_word, sign_mask[2:0], sign_mask[3]);
            read_valid <= 1'b1;
            state      <= SPLIT2;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          if (req) begin
            if (memread && memwrite) access_fault <= 1'b1;
            if (bad) begin
              access_fault <= 1'b1;
              if (memread) begin
                read_data  <= '0;
                read_valid <= 1'b1;
              end
            end else if (led_hit) begin
              if (memread) begin
                read_data  <= led_ext;
                read_valid <= 1'b1;
              end else begin
                led <= write_data[LED_WIDTH-1:0];
              end
            end else if (crossing) begin
              state      <= SPLIT1;
              split_load <= memread;
              lo_buf     <= rd_word;
            end else if (memread) begin
              read_data  <= extend(load_word, sign_mask[2:0], sign_mask[3]);
              read_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_param.sv
// tb_data_mem_param
// Directed bench for data_mem_param: a table of single-cycle accesses with
// hand-computed results, followed by hand-written split-access and
// reset-during-split sequences.
module tb_data_mem_param;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        read_valid;
  logic [7:0]  led;
  logic        clk_stall;
  logic        access_fault;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] SZ_W  = 4'b0111;
  localparam logic [3:0] SZ_H  = 4'b0011;
  localparam logic [3:0] SZ_HS = 4'b1011;
  localparam logic [3:0] SZ_B  = 4'b0001;
  localparam logic [3:0] SZ_BS = 4'b1001;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [3:0]  sm;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_fault;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[$];

  data_mem_param #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h1000),
    .LED_ADDR   (32'h2000),
    .LED_WIDTH  (8),
    .INIT_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .write_data  (write_data),
    .memwrite    (memwrite),
    .memread     (memread),
    .sign_mask   (sign_mask),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .led         (led),
    .clk_stall   (clk_stall),
    .access_fault(access_fault)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkv(logic [31:0] a, logic [31:0] wd, logic rd, logic wr,
                               logic [3:0] sm, logic [31:0] ed, logic ev, logic ef,
                               logic [7:0] el);
    vec_t v;
    v.a = a; v.wd = wd; v.rd = rd; v.wr = wr; v.sm = sm;
    v.exp_data = ed; v.exp_valid = ev; v.exp_fault = ef; v.exp_led = el;
    return v;
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                               input logic wr, input logic [3:0] sm);
    addr       = a;
    write_data = wd;
    memread    = rd;
    memwrite   = wr;
    sign_mask  = sm;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 4'b0000);
  endtask

  // Plain aligned/non-crossing load with its one-cycle latency
  task automatic doLoad(input logic [31:0] a, input logic [3:0] sm, input logic [31:0] exp,
                        input string name);
    applyStimulus(a, 32'h0, 1'b1, 1'b0, sm);
    step();
    checkOutput({name, "_valid"}, {31'b0, read_valid}, 32'd1);
    checkOutput({name, "_data"}, read_data, exp);
    goIdle();
  endtask

  // Word-crossing load: two stalled cycles, result in the third
  task automatic crossLoad(input logic [31:0] a, input logic [3:0] sm, input logic [31:0] exp,
                           input string name);
    applyStimulus(a, 32'h0, 1'b1, 1'b0, sm);
    #3;
    checkOutput({name, "_stall_c1"}, {31'b0, clk_stall}, 32'd1);
    step();
    checkOutput({name, "_stall_c2"}, {31'b0, clk_stall}, 32'd1);
    checkOutput({name, "_valid_c2"}, {31'b0, read_valid}, 32'd0);
    step();
    checkOutput({name, "_valid_c3"}, {31'b0, read_valid}, 32'd1);
    checkOutput({name, "_data"}, read_data, exp);
    goIdle();
    #1;
    checkOutput({name, "_stall_c3"}, {31'b0, clk_stall}, 32'd0);
    step();
    checkOutput({name, "_valid_end"}, {31'b0, read_valid}, 32'd0);
  endtask

  initial begin
    // Vector table: each entry is one cycle, results sampled just after the edge
    vecs.push_back(mkv(32'h1000, 32'hDEADBEEF, 0, 1, SZ_W,  32'h0,        0, 0, 8'h00));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, SZ_W,  32'hDEADBEEF, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1003, 32'h00000080, 0, 1, SZ_B,  32'h0,        0, 0, 8'h00));
    vecs.push_back(mkv(32'h1003, 32'h0,        1, 0, SZ_BS, 32'hFFFFFF80, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1003, 32'h0,        1, 0, SZ_B,  32'h00000080, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, SZ_W,  32'h80ADBEEF, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, SZ_HS, 32'hFFFFBEEF, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1002, 32'h0,        1, 0, SZ_H,  32'h000080AD, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1001, 32'h0,        1, 0, SZ_BS, 32'hFFFFFFBE, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h1002, 32'h00001234, 0, 1, SZ_H,  32'h0,        0, 0, 8'h00));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, SZ_W,  32'h1234BEEF, 1, 0, 8'h00));
    vecs.push_back(mkv(32'h2000, 32'h000000A5, 0, 1, SZ_W,  32'h0,        0, 0, 8'hA5));
    vecs.push_back(mkv(32'h2000, 32'h0,        1, 0, SZ_W,  32'h000000A5, 1, 0, 8'hA5));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, SZ_W,  32'h1234BEEF, 1, 0, 8'hA5));
    vecs.push_back(mkv(32'h0FFC, 32'hCAFEF00D, 0, 1, SZ_W,  32'h0,        0, 1, 8'hA5));
    vecs.push_back(mkv(32'h2004, 32'h0,        1, 0, SZ_W,  32'h0,        1, 1, 8'hA5));
    vecs.push_back(mkv(32'h0FFF, 32'h0,        1, 0, SZ_B,  32'h0,        1, 1, 8'hA5));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, 4'b0010, 32'h0,      1, 1, 8'hA5));
    vecs.push_back(mkv(32'h1000, 32'h0,        0, 1, 4'b0101, 32'h0,      0, 1, 8'hA5));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 1, SZ_W,  32'h1234BEEF, 1, 1, 8'hA5));
    vecs.push_back(mkv(32'h1000, 32'h0,        1, 0, SZ_W,  32'h1234BEEF, 1, 0, 8'hA5));
    vecs.push_back(mkv(32'h1FFC, 32'h55667788, 0, 1, SZ_W,  32'h0,        0, 0, 8'hA5));
    vecs.push_back(mkv(32'h1FFC, 32'h0,        1, 0, SZ_W,  32'h55667788, 1, 0, 8'hA5));
    vecs.push_back(mkv(32'h1FFE, 32'h0,        1, 0, SZ_HS, 32'h00005566, 1, 0, 8'hA5));
    vecs.push_back(mkv(32'h1FFE, 32'h0,        1, 0, SZ_W,  32'h0,        1, 1, 8'hA5));
    vecs.push_back(mkv(32'h1FFF, 32'h0,        1, 0, SZ_H,  32'h0,        1, 1, 8'hA5));
    vecs.push_back(mkv(32'h1FFE, 32'hAAAAAAAA, 0, 1, SZ_W,  32'h0,        0, 1, 8'hA5));
    vecs.push_back(mkv(32'h1FFC, 32'h0,        1, 0, SZ_W,  32'h55667788, 1, 0, 8'hA5));
    vecs.push_back(mkv(32'h1004, 32'hAAAAAAAA, 0, 1, SZ_W,  32'h0,        0, 0, 8'hA5));
    vecs.push_back(mkv(32'h1008, 32'hBBBBBBBB, 0, 1, SZ_W,  32'h0,        0, 0, 8'hA5));
    vecs.push_back(mkv(32'h1010, 32'h00000000, 0, 1, SZ_W,  32'h0,        0, 0, 8'hA5));
    vecs.push_back(mkv(32'h1014, 32'h00000000, 0, 1, SZ_W,  32'h0,        0, 0, 8'hA5));

    // Reset and check every output's reset value
    rst = 1'b1;
    goIdle();
    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_read_data", read_data, 32'h0);
    checkOutput("rst_read_valid", {31'b0, read_valid}, 32'd0);
    checkOutput("rst_led", {24'b0, led}, 32'h0);
    checkOutput("rst_clk_stall", {31'b0, clk_stall}, 32'd0);
    checkOutput("rst_access_fault", {31'b0, access_fault}, 32'd0);
    step();

    // Table-driven single-cycle accesses; none of these may stall
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].wr, vecs[i].sm);
      #3;
      checkOutput($sformatf("v%0d_stall", i), {31'b0, clk_stall}, 32'd0);
      step();
      checkOutput($sformatf("v%0d_valid", i), {31'b0, read_valid}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("v%0d_fault", i), {31'b0, access_fault}, {31'b0, vecs[i].exp_fault});
      checkOutput($sformatf("v%0d_led", i), {24'b0, led}, {24'b0, vecs[i].exp_led});
      if (vecs[i].exp_valid)
        checkOutput($sformatf("v%0d_data", i), read_data, vecs[i].exp_data);
    end
    goIdle();
    step();

    // Word-crossing store: two stalled cycles, halves land in adjacent words
    applyStimulus(32'h1006, 32'h11223344, 1'b0, 1'b1, SZ_W);
    #3;
    checkOutput("xs_stall_c1", {31'b0, clk_stall}, 32'd1);
    step();
    checkOutput("xs_stall_c2", {31'b0, clk_stall}, 32'd1);
    step();
    goIdle();
    #1;
    checkOutput("xs_stall_end", {31'b0, clk_stall}, 32'd0);
    checkOutput("xs_fault", {31'b0, access_fault}, 32'd0);
    step();
    doLoad(32'h1004, SZ_W, 32'h3344AAAA, "xs_word_lo");
    doLoad(32'h1008, SZ_W, 32'hBBBB1122, "xs_word_hi");

    // Word-crossing loads of several sizes and extensions
    crossLoad(32'h1006, SZ_W,  32'h11223344, "xl_word");
    crossLoad(32'h1003, SZ_HS, 32'hFFFFAA12, "xl_half_s");
    crossLoad(32'h1007, SZ_H,  32'h00002233, "xl_half_u");

    // Reset while a crossing store sits in SPLIT1: only the low half commits
    applyStimulus(32'h1012, 32'h99887766, 1'b0, 1'b1, SZ_W);
    #3;
    checkOutput("rs_stall_c1", {31'b0, clk_stall}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("rs_stall", {31'b0, clk_stall}, 32'd0);
    checkOutput("rs_valid", {31'b0, read_valid}, 32'd0);
    checkOutput("rs_fault", {31'b0, access_fault}, 32'd0);
    checkOutput("rs_led", {24'b0, led}, 32'h0);
    checkOutput("rs_data", read_data, 32'h0);
    step();
    rst = 1'b0;
    goIdle();
    step();
    checkOutput("rs_valid_after", {31'b0, read_valid}, 32'd0);
    doLoad(32'h1010, SZ_W, 32'h77660000, "rs_word_lo");
    doLoad(32'h1014, SZ_W, 32'h00000000, "rs_word_hi");
    doLoad(32'h1004, SZ_W, 32'h3344AAAA, "rs_other");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
